// File: rtl/unidade_controle_if.sv
// Control/datapath bus between unidade_controle (master) and the RISC-V datapath (slave).
interface unidade_controle_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IMEM_AW = 7
);
  logic [31:0]        instr;
  logic [XLEN-1:0]    imediato_I;
  logic [XLEN-1:0]    imediato_S;
  logic [XLEN-1:0]    imediato_J;
  logic [XLEN-1:0]    imediato_U;
  logic [XLEN-1:0]    doutULA;
  logic [XLEN-1:0]    pc;
  logic [IMEM_AW-1:0] endr;
  logic               ir_load;
  logic [4:0]         Ra;
  logic [4:0]         Rb;
  logic [4:0]         Rw;
  logic               WeR;
  logic               WeM;
  logic               soma_ou_subtrai;
  logic               subtraindo;
  logic               imediato;
  logic [XLEN-1:0]    constante;
  logic [1:0]         sel_dinR;
  logic [XLEN-1:0]    dinR_pc;

  modport master (
    input  instr, imediato_I, imediato_S, imediato_J, imediato_U, doutULA,
    output pc, endr, ir_load, Ra, Rb, Rw, WeR, WeM, soma_ou_subtrai,
           subtraindo, imediato, constante, sel_dinR, dinR_pc
  );

  modport slave (
    output instr, imediato_I, imediato_S, imediato_J, imediato_U, doutULA,
    input  pc, endr, ir_load, Ra, Rb, Rw, WeR, WeM, soma_ou_subtrai,
           subtraindo, imediato, constante, sel_dinR, dinR_pc
  );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control FSM (ld/sd/add/sub/addi/jal/jalr/auipc); owns the PC.
// Optional retired-instruction counter enabled by CONTROLE_INSTRET_EN.
module unidade_controle #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      IMEM_AW  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  unidade_controle_if.master  bus,
  output logic                ilegal,
  output logic [2:0]          estado
`ifdef CONTROLE_INSTRET_EN
  , output logic [63:0]       instret
`endif
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    CARREGA    = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    PARADO     = 3'd6
  } estado_t;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_ADDI, K_LD, K_SD, K_JAL, K_JALR, K_AUIPC, K_ILEGAL
  } instr_t;

  localparam logic [XLEN-1:0] QUATRO   = XLEN'(4);
  localparam logic [XLEN-1:0] MASK_BIT0 = ~XLEN'(1);

  estado_t         st;
  instr_t          kind, dec;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      ra_q, rb_q, rw_q;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic            wer_c, wem_c, ir_c;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];

  always_comb begin
    dec = K_ILEGAL;
    case (opcode)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      dec = K_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) dec = K_SUB;
      end
      7'b0010011: if (f3 == 3'b000) dec = K_ADDI;
      7'b0000011: if (f3 == 3'b011) dec = K_LD;
      7'b0100011: if (f3 == 3'b011) dec = K_SD;
      7'b1101111: dec = K_JAL;
      7'b1100111: if (f3 == 3'b000) dec = K_JALR;
      7'b0010111: dec = K_AUIPC;
      default:    dec = K_ILEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= BUSCA;
      pc_q   <= RESET_PC;
      ilegal <= 1'b0;
      kind   <= K_ILEGAL;
      ra_q   <= '0;
      rb_q   <= '0;
      rw_q   <= '0;
`ifdef CONTROLE_INSTRET_EN
      instret <= '0;
`endif
    end else begin
      case (st)
        BUSCA:   st <= CARREGA;
        CARREGA: st <= DECODIFICA;
        DECODIFICA: begin
          // Register fields are captured here so they stay put through write-back.
          kind <= dec;
          ra_q <= bus.instr[19:15];
          rb_q <= bus.instr[24:20];
          rw_q <= bus.instr[11:7];
          if (dec == K_ILEGAL) begin
            st     <= PARADO;
            ilegal <= 1'b1;
          end else begin
            st <= EXECUTA;
          end
        end
        EXECUTA: begin
          if (kind == K_LD) begin
            st <= MEMORIA;
          end else begin
            st <= BUSCA;
`ifdef CONTROLE_INSTRET_EN
            instret <= instret + 64'd1;
`endif
            case (kind)
              K_JAL:   pc_q <= pc_q + bus.imediato_J;
              K_JALR:  pc_q <= bus.doutULA & MASK_BIT0;
              default: pc_q <= pc_q + QUATRO;
            endcase
          end
        end
        MEMORIA: st <= ESCRITA;
        ESCRITA: begin
          st   <= BUSCA;
          pc_q <= pc_q + QUATRO;
`ifdef CONTROLE_INSTRET_EN
          instret <= instret + 64'd1;
`endif
        end
        PARADO:  st <= PARADO;
        default: st <= BUSCA;
      endcase
    end
  end

  always_comb begin
    bus.Ra              = '0;
    bus.Rb              = '0;
    bus.Rw              = '0;
    bus.soma_ou_subtrai = 1'b0;
    bus.subtraindo      = 1'b0;
    bus.imediato        = 1'b0;
    bus.constante       = '0;
    bus.sel_dinR        = 2'd0;
    bus.dinR_pc         = '0;
    wer_c               = 1'b0;
    wem_c               = 1'b0;
    ir_c                = 1'b0;
    case (st)
      CARREGA: ir_c = 1'b1;
      DECODIFICA: begin
        bus.Ra = bus.instr[19:15];
        bus.Rb = bus.instr[24:20];
      end
      EXECUTA, MEMORIA, ESCRITA: begin
        bus.Ra              = ra_q;
        bus.Rb              = rb_q;
        bus.Rw              = rw_q;
        bus.soma_ou_subtrai = 1'b1;
        // Only ld reaches MEMORIA/ESCRITA, so every other case is EXECUTA-only.
        case (kind)
          K_ADD: wer_c = 1'b1;
          K_SUB: begin
            bus.subtraindo = 1'b1;
            wer_c          = 1'b1;
          end
          K_ADDI: begin
            bus.imediato  = 1'b1;
            bus.constante = bus.imediato_I;
            wer_c         = 1'b1;
          end
          K_LD: begin
            bus.imediato  = 1'b1;
            bus.constante = bus.imediato_I;
            if (st == ESCRITA) begin
              bus.sel_dinR = 2'd1;
              wer_c        = 1'b1;
            end
          end
          K_SD: begin
            bus.imediato  = 1'b1;
            bus.constante = bus.imediato_S;
            wem_c         = 1'b1;
          end
          K_JAL: begin
            bus.dinR_pc  = pc_q + QUATRO;
            bus.sel_dinR = 2'd2;
            wer_c        = 1'b1;
          end
          K_JALR: begin
            bus.imediato  = 1'b1;
            bus.constante = bus.imediato_I;
            bus.dinR_pc   = pc_q + QUATRO;
            bus.sel_dinR  = 2'd2;
            wer_c         = 1'b1;
          end
          K_AUIPC: begin
            bus.dinR_pc  = pc_q + bus.imediato_U;
            bus.sel_dinR = 2'd2;
            wer_c        = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.WeR     = wer_c && rst_n && (rw_q != 5'd0);
  assign bus.WeM     = wem_c && rst_n;
  assign bus.ir_load = ir_c && rst_n;
  assign bus.pc      = pc_q;
  assign bus.endr    = pc_q[IMEM_AW+1:2];
  assign estado      = st;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle.
module tb_unidade_controle;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned IMEM_AW = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ilegal;
  logic [2:0]  estado;
`ifdef CONTROLE_INSTRET_EN
  logic [63:0] instret;
`endif
  int unsigned errors = 0;
  int unsigned checks = 0;

  unidade_controle_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

  unidade_controle #(
    .XLEN(XLEN),
    .RESET_PC(64'h0),
    .IMEM_AW(IMEM_AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master),
    .ilegal(ilegal),
    .estado(estado)
`ifdef CONTROLE_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] ins, input logic [63:0] ii, input logic [63:0] is,
                      input logic [63:0] ij, input logic [63:0] iu, input logic [63:0] ula);
    bus.instr      = ins;
    bus.imediato_I = ii;
    bus.imediato_S = is;
    bus.imediato_J = ij;
    bus.imediato_U = iu;
    bus.doutULA    = ula;
  endtask

  initial begin
    load(32'h00000013, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    step(2);
    chk("rst_estado", 64'(estado), 64'd0);
    chk("rst_WeR", 64'(bus.WeR), 64'd0);
    chk("rst_ir_load", 64'(bus.ir_load), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_pc", bus.pc, 64'd0);
    chk("rel_estado", 64'(estado), 64'd0);
    chk("rel_ilegal", 64'(ilegal), 64'd0);
`ifdef CONTROLE_INSTRET_EN
    chk("rel_instret", instret, 64'd0);
`endif
    step(1);
    chk("carrega_estado", 64'(estado), 64'd1);
    chk("carrega_ir_load", 64'(bus.ir_load), 64'd1);
    step(1);
    chk("decod_estado", 64'(estado), 64'd2);
    chk("decod_ir_load", 64'(bus.ir_load), 64'd0);
    step(1);
    chk("addi_x0_estado", 64'(estado), 64'd3);
    chk("addi_x0_imediato", 64'(bus.imediato), 64'd1);
    chk("addi_x0_WeR", 64'(bus.WeR), 64'd0);
    step(1);
    chk("addi_x0_pc", bus.pc, 64'd4);
    chk("addi_x0_estado_after", 64'(estado), 64'd0);

    // add x3,x1,x2
    load(32'h002081B3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd30);
    step(2);
    chk("add_dec_Ra", 64'(bus.Ra), 64'd1);
    chk("add_dec_Rb", 64'(bus.Rb), 64'd2);
    step(1);
    chk("add_Ra", 64'(bus.Ra), 64'd1);
    chk("add_Rb", 64'(bus.Rb), 64'd2);
    chk("add_Rw", 64'(bus.Rw), 64'd3);
    chk("add_sub", 64'(bus.subtraindo), 64'd0);
    chk("add_imm", 64'(bus.imediato), 64'd0);
    chk("add_soma", 64'(bus.soma_ou_subtrai), 64'd1);
    chk("add_WeR", 64'(bus.WeR), 64'd1);
    chk("add_sel", 64'(bus.sel_dinR), 64'd0);
    step(1);
    chk("add_pc", bus.pc, 64'd8);
    chk("add_WeR_after", 64'(bus.WeR), 64'd0);

    // sub x3,x1,x2
    load(32'h402081B3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    step(3);
    chk("sub_sub", 64'(bus.subtraindo), 64'd1);
    chk("sub_WeR", 64'(bus.WeR), 64'd1);
    step(1);
    chk("sub_pc", bus.pc, 64'd12);

    // ld x1,8(x0): six edges from BUSCA to the next BUSCA
    load(32'h00803083, 64'd8, 64'd0, 64'd0, 64'd0, 64'd8);
    step(3);
    chk("ld_exe_const", bus.constante, 64'd8);
    chk("ld_exe_imm", 64'(bus.imediato), 64'd1);
    chk("ld_exe_WeR", 64'(bus.WeR), 64'd0);
    step(1);
    chk("ld_mem_estado", 64'(estado), 64'd4);
    chk("ld_mem_const", bus.constante, 64'd8);
    chk("ld_mem_WeR", 64'(bus.WeR), 64'd0);
    chk("ld_mem_pc", bus.pc, 64'd12);
    step(1);
    chk("ld_esc_estado", 64'(estado), 64'd5);
    chk("ld_esc_const", bus.constante, 64'd8);
    chk("ld_esc_WeR", 64'(bus.WeR), 64'd1);
    chk("ld_esc_sel", 64'(bus.sel_dinR), 64'd1);
    chk("ld_esc_Rw", 64'(bus.Rw), 64'd1);
    step(1);
    chk("ld_pc", bus.pc, 64'd16);
    chk("ld_estado_after", 64'(estado), 64'd0);

    // sd x1,40(x0)
    load(32'h02103423, 64'd0, 64'd40, 64'd0, 64'd0, 64'd40);
    step(2);
    chk("sd_dec_WeM", 64'(bus.WeM), 64'd0);
    step(1);
    chk("sd_WeM", 64'(bus.WeM), 64'd1);
    chk("sd_const", bus.constante, 64'd40);
    chk("sd_WeR", 64'(bus.WeR), 64'd0);
    step(1);
    chk("sd_WeM_after", 64'(bus.WeM), 64'd0);
    chk("sd_pc", bus.pc, 64'h14);

    // jal x1,12 at 0x14
    load(32'h00C000EF, 64'd0, 64'd0, 64'd12, 64'd0, 64'd0);
    step(3);
    chk("jal12_dinR_pc", bus.dinR_pc, 64'h18);
    step(1);
    chk("jal12_pc", bus.pc, 64'h20);

    // jal x1,-8 at 0x20
    load(32'hFF9FF0EF, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
    step(3);
    chk("jal_dinR_pc", bus.dinR_pc, 64'h24);
    chk("jal_Rw", 64'(bus.Rw), 64'd1);
    chk("jal_WeR", 64'(bus.WeR), 64'd1);
    chk("jal_sel", 64'(bus.sel_dinR), 64'd2);
    step(1);
    chk("jal_pc", bus.pc, 64'h18);

    // jalr x1,0x41(x0) with ULA = 0x41
    load(32'h041000E7, 64'h41, 64'd0, 64'd0, 64'd0, 64'h41);
    step(3);
    chk("jalr_dinR_pc", bus.dinR_pc, 64'h1C);
    chk("jalr_const", bus.constante, 64'h41);
    chk("jalr_imm", 64'(bus.imediato), 64'd1);
    chk("jalr_sel", 64'(bus.sel_dinR), 64'd2);
    step(1);
    chk("jalr_pc", bus.pc, 64'h40);

    // jal x0,-48 at 0x40: x0 destination suppresses the write
    load(32'hFD1FF06F, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFD0, 64'd0, 64'd0);
    step(3);
    chk("jal_x0_WeR", 64'(bus.WeR), 64'd0);
    step(1);
    chk("jal_x0_pc", bus.pc, 64'h10);

    // auipc x5,0x1 at 0x10
    load(32'h00001297, 64'd0, 64'd0, 64'd0, 64'h1000, 64'd0);
    step(3);
    chk("auipc_dinR_pc", bus.dinR_pc, 64'h1010);
    chk("auipc_Rw", 64'(bus.Rw), 64'd5);
    chk("auipc_WeR", 64'(bus.WeR), 64'd1);
    step(1);
    chk("auipc_pc", bus.pc, 64'h14);
    chk("endr", 64'(bus.endr), 64'd5);
`ifdef CONTROLE_INSTRET_EN
    chk("instret_10", instret, 64'd10);
`endif

    // Illegal opcode halts with pc frozen
    load(32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd0);
    step(3);
    chk("ilegal_estado", 64'(estado), 64'd6);
    chk("ilegal_flag", 64'(ilegal), 64'd1);
    step(20);
    chk("parado_estado", 64'(estado), 64'd6);
    chk("parado_pc", bus.pc, 64'h14);
    chk("parado_flag", 64'(ilegal), 64'd1);
    chk("parado_WeR", 64'(bus.WeR), 64'd0);
    chk("parado_ir_load", 64'(bus.ir_load), 64'd0);
`ifdef CONTROLE_INSTRET_EN
    chk("parado_instret", instret, 64'd10);
`endif
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    #1;
    chk("rst2_ilegal", 64'(ilegal), 64'd0);
    chk("rst2_pc", bus.pc, 64'd0);
    chk("rst2_estado", 64'(estado), 64'd0);

    // Unsupported funct7 on an R-type opcode
    load(32'h022081B3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    step(3);
    chk("f7_ilegal_estado", 64'(estado), 64'd6);
    chk("f7_ilegal_flag", 64'(ilegal), 64'd1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    #1;
    chk("rst3_ilegal", 64'(ilegal), 64'd0);

    // Reset during ld MEMORIA aborts without a write
    load(32'h00803083, 64'd8, 64'd0, 64'd0, 64'd0, 64'd8);
    step(4);
    chk("ldrst_mem_estado", 64'(estado), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("ldrst_WeR_comb", 64'(bus.WeR), 64'd0);
    step(1);
    chk("ldrst_estado", 64'(estado), 64'd0);
    chk("ldrst_WeR", 64'(bus.WeR), 64'd0);
    chk("ldrst_pc", bus.pc, 64'd0);
    step(1);
    chk("ldrst_hold_estado", 64'(estado), 64'd0);
    chk("ldrst_hold_ir_load", 64'(bus.ir_load), 64'd0);
    rst_n = 1'b1;
    load(32'h00000013, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    step(4);
    chk("resume_pc", bus.pc, 64'd4);
`ifdef CONTROLE_INSTRET_EN
    chk("resume_instret", instret, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the RISC-V datapath.
- Fetches from MemoriaInstrucao/RegistradorInstrucao, decodes the instruction and drives the BancoRegistradores, ULA and MemoryData control lines that the bench currently drives by hand.
- Owns the PC.
- Supported instructions: ld, sd, add, sub, addi, jal, jalr, auipc.

Parameters:
RESET_PC, 0, PC value loaded at reset
XLEN, 64, datapath width
IMEM_AW, 7, instruction-memory word-address width (endr)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instr  in  32  RegistradorInstrucao output
imediato_I  in  XLEN  sign-extended I immediate
imediato_S  in  XLEN  sign-extended S immediate
imediato_J  in  XLEN  sign-extended J immediate
imediato_U  in  XLEN  U immediate
doutULA  in  XLEN  ULA result
pc  out  XLEN  program counter
endr  out  IMEM_AW  pc[IMEM_AW+1:2], instruction-memory address
ir_load  out  1  IR capture enable
Ra, Rb, Rw  out  5 each  register-file addresses
WeR  out  1  register write enable
WeM  out  1  data-memory write enable
soma_ou_subtrai  out  1  ULA add/sub operation select
subtraindo  out  1  1 = subtract
imediato  out  1  1 = ULA second operand is constante
constante  out  XLEN  ULA constant
sel_dinR  out  2  write-back source: 0 = doutULA, 1 = doutM, 2 = dinR_pc
dinR_pc  out  XLEN  PC-derived write-back value
ilegal  out  1  sticky unsupported-opcode flag
estado  out  3  current state, for debug

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low at a rising edge: pc = RESET_PC, estado = BUSCA, ilegal = 0.
  - While rst_n is low, WeR, WeM and ir_load are forced to 0 combinationally.
  - Reset asserted mid-instruction aborts the instruction. No write occurs in the reset cycle.
- States (encoding 0-5): BUSCA, CARREGA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, PARADO (6).
- Outputs are Moore, decoded from estado and instr. Defaults in every state: WeR = WeM = ir_load = 0; endr always tracks pc.
- BUSCA: instruction memory reads endr. Next state: CARREGA.
- CARREGA: ir_load = 1. Next state: DECODIFICA.
- DECODIFICA:
  - Ra = instr[19:15], Rb = instr[24:20].
  - Opcode checked. Unsupported opcode/funct3/funct7 -> PARADO with ilegal = 1. Otherwise -> EXECUTA.
- Ra and Rb hold their DECODIFICA values through EXECUTA, MEMORIA and ESCRITA. Rw = instr[11:7] in those states.
- EXECUTA, per instruction:
  - add (0110011, f3 000, f7 0000000): imediato = 0, subtraindo = 0, WeR = 1, sel_dinR = 0. pc += 4 -> BUSCA.
  - sub (f7 0100000): same as add with subtraindo = 1.
  - addi (0010011, f3 000): imediato = 1, constante = imediato_I, WeR = 1, sel_dinR = 0. pc += 4.
  - ld (0000011, f3 011): imediato = 1, constante = imediato_I. -> MEMORIA.
  - sd (0100011, f3 011): imediato = 1, constante = imediato_S, WeM = 1. pc += 4.
  - jal (1101111): dinR_pc = pc + 4, sel_dinR = 2, WeR = 1. pc += imediato_J.
  - jalr (1100111, f3 000): imediato = 1, constante = imediato_I, dinR_pc = pc + 4, sel_dinR = 2, WeR = 1. pc = doutULA with bit 0 cleared.
  - auipc (0010111): dinR_pc = pc + imediato_U, sel_dinR = 2, WeR = 1. pc += 4.
- soma_ou_subtrai = 1 in EXECUTA, MEMORIA and ESCRITA for all instructions.
- MEMORIA (ld only): ULA controls held so the address stays stable. -> ESCRITA.
- ESCRITA (ld only): ULA controls held, sel_dinR = 1, WeR = 1. pc += 4 -> BUSCA.
- Latency:
  - ALU/jump/sd retire in 4 cycles (BUSCA .. EXECUTA).
  - ld retires in 6 cycles.
  - The register write takes effect at the clock edge ending the write state.
- x0: WeR is forced to 0 whenever Rw == 0.
- PARADO: absorbing until reset. All enables 0, pc frozen, ilegal held at 1.
- Arithmetic: all PC arithmetic is modulo 2^XLEN; wrap-around is silent. endr ignores pc bits above IMEM_AW+1.

Optional Feature:
- Macro: CONTROLE_INSTRET_EN.
- Defined:
  - Extra output instret (64 bits), reset to 0.
  - Increments by 1 at the edge that retires each instruction (EXECUTA exit to BUSCA, or ESCRITA exit).
  - Does not count in PARADO; wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC = 0, IR = 0x00000013 (addi x0,x0,0) -> cycle after release: pc = 0, estado = BUSCA, WeR = 0. After 4 cycles pc = 4; WeR stays 0 because rd = x0.
- add x3,x1,x2 (0x002081B3) with ULA returning 30 -> in EXECUTA: Ra = 1, Rb = 2, Rw = 3, subtraindo = 0, imediato = 0, WeR = 1, sel_dinR = 0; pc 4 -> 8.
- ld x1,8(x0) (0x00803083) -> constante = 8 in EXECUTA/MEMORIA/ESCRITA; WeR = 1 and sel_dinR = 1 only in ESCRITA; 6 cycles to retire.
- sd x1,40(x0) (0x02103423) -> WeM = 1 for exactly one cycle, constante = 40, WeR = 0; pc += 4.
- jal x1,-8 at pc = 0x20 -> dinR_pc = 0x24, Rw = 1, WeR = 1; next pc = 0x18. jalr with doutULA = 0x41 -> pc = 0x40. auipc x5,0x1 at pc = 0x10 -> dinR_pc = 0x1010.
- IR = 0xFFFFFFFF -> PARADO, ilegal = 1, pc frozen for 20 cycles. rst_n = 0 for one edge -> ilegal = 0, pc = RESET_PC. rst_n pulsed low mid-ld (MEMORIA) -> no WeR pulse.
